// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
// Purpose: state type, default frame geometry and mid-bit vote offsets shared
//          by the RX controller and the future TX controller.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Votes are taken at MID-VOTE_PRE, MID and MID+VOTE_POST within a bit.
  localparam int VOTE_PRE  = 1;
  localparam int VOTE_POST = 1;

  function automatic int mid_point(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchronizer for the serial line
// Purpose: brings the asynchronous serial line into the clk16 domain. Flops
//          reset to 1 so the line reads idle while reset is applied.
// Ports:   clk16          - 16x oversample clock
//          rst            - synchronous reset, active-high
//          serial_data_in - asynchronous serial line
//          rxd_s          - synchronized line (STAGES cycles of delay)
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk16,
  input  logic rst,
  input  logic serial_data_in,
  output logic rxd_s
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk16) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], serial_data_in};
    end
  end

  assign rxd_s = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with 3-sample majority voting
// Purpose: qualifies start bits, samples each bit mid-cell by 2-of-3 majority,
//          assembles LSB-first data, checks the stop bit and hands completed
//          bytes to the consumer with overrun and framing-error reporting.
// Ports:   clk16          - 16x oversample clock, sole clock
//          rst            - synchronous reset, active-high
//          serial_data_in - asynchronous serial line, idle high
//          rx_en          - receiver enable; low aborts a frame in progress
//          data_ready     - consumer accepts para_data_out this cycle
//          ovr_clr        - clears the sticky overrun flag
//          para_data_out  - received data, stable while data_valid=1
//          data_valid     - data available, held until data_ready
//          frame_err      - one-cycle pulse when the stop bit samples low
//          overrun        - sticky: good frame dropped, previous not taken
//          busy           - receiver is not idle
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk16,
  input  logic                 rst,
  input  logic                 serial_data_in,
  input  logic                 rx_en,
  input  logic                 data_ready,
  input  logic                 ovr_clr,
  output logic [DATA_BITS-1:0] para_data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam int MID  = mid_point(OVERSAMPLE);

  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_V0   = OS_W'(MID - VOTE_PRE);
  localparam logic [OS_W-1:0] OS_V1   = OS_W'(MID);
  localparam logic [OS_W-1:0] OS_V2   = OS_W'(MID + VOTE_POST);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_START    = START;
  localparam logic [2:0] ST_DATA     = DATA;
  localparam logic [2:0] ST_STOP     = STOP;
  localparam logic [2:0] ST_BRK_WAIT = BRK_WAIT;

  logic                 rxd_s;
  logic [2:0]           state;
  logic [OS_W-1:0]      os_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 vote_a;
  logic                 vote_b;
  logic                 decide;
  logic                 vote;
  logic                 os_wrap;
  logic                 frame_good;
  logic                 frame_bad;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk16          (clk16),
    .rst            (rst),
    .serial_data_in (serial_data_in),
    .rxd_s          (rxd_s)
  );

  // The third vote is the live rxd_s at the decision edge, so the majority is
  // available the same cycle the last sample would have been captured.
  always_comb begin
    decide     = (os_cnt == OS_V2);
    os_wrap    = (os_cnt == OS_LAST);
    vote       = (vote_a & vote_b) | (vote_a & rxd_s) | (vote_b & rxd_s);
    frame_good = rx_en && (state == ST_STOP) && decide && vote;
    frame_bad  = rx_en && (state == ST_STOP) && decide && !vote;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk16) begin
    if (rst) begin
      vote_a <= 1'b0;
      vote_b <= 1'b0;
    end else begin
      if (os_cnt == OS_V0) vote_a <= rxd_s;
      if (os_cnt == OS_V1) vote_b <= rxd_s;
    end
  end

  always_ff @(posedge clk16) begin
    if (rst) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!rx_en && (state != ST_IDLE)) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_en && !rxd_s) begin
            state  <= ST_START;
            os_cnt <= '0;
          end
        end
        ST_START: begin
          os_cnt <= os_cnt + 1'b1;
          if (decide && vote) begin
            // Start bit did not hold low through mid-cell: treat as glitch.
            state  <= ST_IDLE;
            os_cnt <= '0;
          end else if (os_wrap) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          os_cnt <= os_cnt + 1'b1;
          if (decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (os_wrap) begin
            if (bit_cnt == BC_LAST) state <= ST_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          os_cnt <= os_cnt + 1'b1;
          if (decide) begin
            // Leaving at mid-stop lets the next start edge be caught even
            // when frames are sent back-to-back.
            os_cnt <= '0;
            state  <= vote ? ST_IDLE : ST_BRK_WAIT;
          end
        end
        ST_BRK_WAIT: begin
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk16) begin
    if (rst) begin
      para_data_out <= '0;
      data_valid    <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= frame_bad;

      if (frame_good) begin
        if (!data_valid || data_ready) begin
          para_data_out <= shreg;
          data_valid    <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (frame_good && data_valid && !data_ready) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed and randomized bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam int SYNC = 2;
  // Posedges from driving the start bit to data_valid being visible:
  // one edge into the synchronizer, SYNC stages, then the frame latency.
  localparam int LAT  = 1 + SYNC + (DB + 1) * OS + OS / 2 + 2;

  logic          clk16 = 1'b0;
  logic          rst = 1'b1;
  logic          serial_data_in = 1'b1;
  logic          rx_en = 1'b0;
  logic          data_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [DB-1:0] para_data_out;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   fe_rise = 0;
  int   fe_high = 0;
  logic dv_q = 1'b0;
  logic fe_q = 1'b0;

  uart_rx_ctrl #(
    .DATA_BITS   (DB),
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk16          (clk16),
    .rst            (rst),
    .serial_data_in (serial_data_in),
    .rx_en          (rx_en),
    .data_ready     (data_ready),
    .ovr_clr        (ovr_clr),
    .para_data_out  (para_data_out),
    .data_valid     (data_valid),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16) cyc <= cyc + 1;

  always @(negedge clk16) begin
    if (data_valid === 1'b1 && dv_q !== 1'b1 && rise_cyc < 0) rise_cyc = cyc;
    if (frame_err === 1'b1) begin
      fe_high++;
      if (fe_q !== 1'b1) fe_rise++;
    end
    dv_q = data_valid;
    fe_q = frame_err;
  end

  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits cells of a frame (start, data LSB first, stop),
  // inverting the line for flen cycles from offset foff inside cell fbit.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                            input int fbit, input int foff, input int flen,
                            input bit ready_at_done, input int nbits,
                            output int n0);
    logic [DB+1:0] frame;
    frame = {stop_bit, d, 1'b0};
    n0 = cyc;
    for (int b = 0; b < nbits; b++) begin
      for (int o = 0; o < OS; o++) begin
        serial_data_in = frame[b] ^ (b == fbit && o >= foff && o < foff + flen);
        if (ready_at_done) data_ready = (cyc + 1 == n0 + LAT);
        tick();
      end
    end
    if (ready_at_done) data_ready = 1'b0;
  endtask

  // Reference: each data bit is the 2-of-3 majority of the line at the three
  // centre samples of its cell (offsets MID..MID+2 relative to the start edge).
  function automatic logic [DB-1:0] model_byte(input logic [DB-1:0] d, input int fbit,
                                               input int foff, input int flen);
    logic [DB-1:0] r;
    r = '0;
    for (int i = 0; i < DB; i++) begin
      int ones;
      ones = 0;
      for (int o = OS / 2; o <= OS / 2 + 2; o++) begin
        if (d[i] ^ (i + 1 == fbit && o >= foff && o < foff + flen)) ones++;
      end
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  initial begin
    int n0;
    int fe_r0;
    int fe_h0;
    int busy_drop;
    logic [DB-1:0] d;
    logic [DB-1:0] exp_b;
    int fb;
    int fo;
    int fl;

    // Reset state
    rst = 1'b1;
    ticks(4);
    check("rst_data", para_data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    rx_en = 1'b1;
    ticks(4);

    // Good frame 0xA5 with latency check
    rise_cyc = -1;
    fe_r0 = fe_rise;
    send_frame(8'hA5, 1'b1, -1, 0, 0, 1'b0, DB + 2, n0);
    ticks(2);
    check("good_latency", rise_cyc, n0 + LAT);
    check("good_data", para_data_out, 8'hA5);
    check("good_valid", data_valid, 1);
    check("good_ferr", fe_rise - fe_r0, 0);
    check("good_ovr", overrun, 0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("ack_valid", data_valid, 0);
    check("ack_hold", para_data_out, 8'hA5);

    // Glitch: 4 low cycles is a false start
    ticks(4);
    rise_cyc = -1;
    n0 = cyc;
    serial_data_in = 1'b0;
    ticks(4);
    serial_data_in = 1'b1;
    ticks(n0 + 1 + SYNC + OS / 2 + 1 - cyc);
    check("glitch_busy_hi", busy, 1);
    tick();
    check("glitch_busy_lo", busy, 0);
    ticks(20);
    check("glitch_valid", rise_cyc, -1);
    check("glitch_ferr", fe_rise - fe_r0, 0);

    // Noise: one-cycle flip mid-cell of data bit 3 is outvoted
    rise_cyc = -1;
    send_frame(8'h3C, 1'b1, 4, OS / 2 + 1, 1, 1'b0, DB + 2, n0);
    ticks(2);
    check("noise_data", para_data_out, 8'h3C);
    check("noise_latency", rise_cyc, n0 + LAT);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;

    // Randomized frames with one- or two-cycle disturbances in a data cell
    for (int k = 0; k < 8; k++) begin
      ticks($urandom_range(0, 6));
      d = DB'($urandom);
      fb = $urandom_range(1, DB);
      fo = $urandom_range(1, OS - 2);
      fl = $urandom_range(1, 2);
      exp_b = model_byte(d, fb, fo, fl);
      rise_cyc = -1;
      send_frame(d, 1'b1, fb, fo, fl, 1'b0, DB + 2, n0);
      ticks(2);
      check($sformatf("rand%0d_latency", k), rise_cyc, n0 + LAT);
      check($sformatf("rand%0d_data", k), para_data_out, exp_b);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check($sformatf("rand%0d_ack", k), data_valid, 0);
    end

    // Framing error: stop bit low, line held low afterwards
    rise_cyc = -1;
    fe_r0 = fe_rise;
    fe_h0 = fe_high;
    send_frame(8'h55, 1'b0, -1, 0, 0, 1'b0, DB + 2, n0);
    busy_drop = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b1) busy_drop++;
    end
    check("ferr_pulses", fe_rise - fe_r0, 1);
    check("ferr_width", fe_high - fe_h0, 1);
    check("ferr_no_valid", rise_cyc, -1);
    check("ferr_brk_hold", busy_drop, 0);
    serial_data_in = 1'b1;
    ticks(SYNC);
    check("brk_still_busy", busy, 1);
    tick();
    check("brk_release", busy, 0);
    ticks(4);

    // Overrun: two back-to-back frames with no consumer
    send_frame(8'h11, 1'b1, -1, 0, 0, 1'b0, DB + 2, n0);
    send_frame(8'h22, 1'b1, -1, 0, 0, 1'b0, DB + 2, n0);
    ticks(2);
    check("ovr_data", para_data_out, 8'h11);
    check("ovr_valid", data_valid, 1);
    check("ovr_set", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    check("ovr_clr_keep", para_data_out, 8'h11);
    // data_ready on the completion cycle lets the new byte replace the old
    send_frame(8'h22, 1'b1, -1, 0, 0, 1'b1, DB + 2, n0);
    ticks(2);
    check("ready_same_data", para_data_out, 8'h22);
    check("ready_same_valid", data_valid, 1);
    check("ready_same_ovr", overrun, 0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;

    // Abort with rx_en low mid-DATA
    rise_cyc = -1;
    fe_r0 = fe_rise;
    send_frame(8'h99, 1'b1, -1, 0, 0, 1'b0, 4, n0);
    rx_en = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    serial_data_in = 1'b1;
    ticks(4);
    rx_en = 1'b1;
    ticks(20);
    check("abort_valid", rise_cyc, -1);
    check("abort_ferr", fe_rise - fe_r0, 0);
    check("abort_ovr", overrun, 0);

    // Reset mid-frame with data pending and overrun set
    send_frame(8'h5A, 1'b1, -1, 0, 0, 1'b0, DB + 2, n0);
    send_frame(8'h66, 1'b1, -1, 0, 0, 1'b0, DB + 2, n0);
    ticks(2);
    check("pre_rst_ovr", overrun, 1);
    send_frame(8'h77, 1'b1, -1, 0, 0, 1'b0, 5, n0);
    rst = 1'b1;
    serial_data_in = 1'b1;
    tick();
    check("mid_rst_data", para_data_out, 0);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err, 0);
    rst = 1'b0;
    ticks(4);
    rise_cyc = -1;
    send_frame(8'hF0, 1'b1, -1, 0, 0, 1'b0, DB + 2, n0);
    ticks(2);
    check("post_rst_data", para_data_out, 8'hF0);
    check("post_rst_latency", rise_cyc, n0 + LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
